// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit
//
// Owns the architectural fetch PC at the front of the IF stage and is its only writer.
// Sequential fetch runs through an instruction-memory req/ready handshake. MEM-stage
// branch/jump redirects move the PC and squash the younger pipeline registers with a
// one-cycle flush pulse.
//
// Optional feature macro: BRANCH_MISALIGN_TRAP_EN
//   defined   : a redirect target with bits[1:0] != 0 is replaced by TRAP_VECTOR, and
//               misalign_o pulses for one cycle, aligned with the flush outputs.
//   undefined : bits[1:0] of the redirect target are forced to 0, and misalign_o is 0.
//
// Ports
//   clk, rst               clock (rising edge), synchronous active-high reset
//   stall_i                do not start a new fetch (never drops an outstanding one)
//   branch_jump_request_i  MEM-stage redirect request
//   pc_sel_i               PLUS4 (00) / BRANCH (01) / JALR (10); 11 is treated as no redirect
//   branch_target_i        BRANCH/JAL target
//   jalr_target_i          JALR target
//   imem_req_o/addr_o      fetch request and address (address held until imem_ready_i)
//   imem_ready_i           fetch accepted/completed this cycle
//   if_valid_o             delivered instruction is on the correct path
//   if_pc_o, if_pc_plus4_o PC of the delivered instruction, and that PC + 4
//   flush_*_o              one-cycle squash of IF/ID, ID/EX and EX/MEM
//   misalign_o             misaligned redirect trapped (macro builds only)

module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_jump_request_i,
    input  logic [1:0]  pc_sel_i,
    input  logic [31:0] branch_target_i,
    input  logic [31:0] jalr_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_pc_plus4_o,
    output logic        flush_if_id_o,
    output logic        flush_id_ex_o,
    output logic        flush_ex_mem_o,
    output logic        misalign_o
);

    // Encodings shared with defines.v (PC_SEL_PLUS4 = 2'b00)
    localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
    localparam logic [1:0] PC_SEL_JALR   = 2'b10;

    // StPend plays the role of pend_valid: a redirect target is latched while a request
    // is still outstanding.
    typedef enum logic [1:0] {StBoot, StFetch, StIdle, StPend} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_pc_plus4_q, if_pc_plus4_d;
    logic        flush_q, flush_d;
    logic        misalign_q, misalign_d;

    logic        redirect;
    logic        misaligned;
    logic [31:0] raw_target;
    logic [31:0] target;
    logic        accept;

    // Redirect decode and target select
    always_comb begin
        redirect   = branch_jump_request_i && (state_q != StBoot) &&
                     ((pc_sel_i == PC_SEL_BRANCH) || (pc_sel_i == PC_SEL_JALR));
        raw_target = (pc_sel_i == PC_SEL_JALR) ? jalr_target_i : branch_target_i;
`ifdef BRANCH_MISALIGN_TRAP_EN
        misaligned = (raw_target[1:0] != 2'b00);
        target     = misaligned ? TRAP_VECTOR : raw_target;
`else
        misaligned = 1'b0;
        target     = {raw_target[31:2], 2'b00};
`endif
    end

`ifndef BRANCH_MISALIGN_TRAP_EN
    logic unused_trap_vector;
    assign unused_trap_vector = ^TRAP_VECTOR;
`endif

    assign imem_req_o  = (state_q == StFetch) || (state_q == StPend);
    assign imem_addr_o = pc_q;
    assign accept      = imem_req_o && imem_ready_i;

    // Next-state logic
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_target_d = pend_target_q;
        if_valid_d    = 1'b0;
        if_pc_d       = if_pc_q;
        if_pc_plus4_d = if_pc_plus4_q;
        flush_d       = redirect;
        misalign_d    = redirect && misaligned;

        // The delivery PC is captured on every accept; if_valid_d decides if it counts.
        if (accept) begin
            if_pc_d       = pc_q;
            if_pc_plus4_d = pc_q + 32'd4;
        end

        unique case (state_q)
            StBoot: begin
                state_d = StFetch;
            end
            StFetch: begin
                if (redirect) begin
                    if (imem_ready_i) begin
                        // Delivery this cycle is wrong-path; refetch from target at once.
                        pc_d    = target;
                        state_d = StFetch;
                    end else begin
                        pend_target_d = target;
                        state_d       = StPend;
                    end
                end else if (imem_ready_i) begin
                    if_valid_d = 1'b1;
                    pc_d       = pc_q + 32'd4;
                    state_d    = stall_i ? StIdle : StFetch;
                end
            end
            StIdle: begin
                if (redirect) begin
                    pc_d    = target;
                    state_d = StFetch;
                end else if (!stall_i) begin
                    state_d = StFetch;
                end
            end
            StPend: begin
                if (redirect) begin
                    pend_target_d = target;
                end
                if (imem_ready_i) begin
                    // The completing instruction is wrong-path; the newest target wins.
                    pc_d    = redirect ? target : pend_target_q;
                    state_d = StFetch;
                end
            end
            default: begin
                state_d = StBoot;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StBoot;
            pc_q          <= RESET_PC;
            pend_target_q <= 32'h0;
            if_valid_q    <= 1'b0;
            if_pc_q       <= 32'h0;
            if_pc_plus4_q <= 32'h0;
            flush_q       <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_target_q <= pend_target_d;
            if_valid_q    <= if_valid_d;
            if_pc_q       <= if_pc_d;
            if_pc_plus4_q <= if_pc_plus4_d;
            flush_q       <= flush_d;
            misalign_q    <= misalign_d;
        end
    end

    assign if_valid_o     = if_valid_q;
    assign if_pc_o        = if_pc_q;
    assign if_pc_plus4_o  = if_pc_plus4_q;
    assign flush_if_id_o  = flush_q;
    assign flush_id_ex_o  = flush_q;
    assign flush_ex_mem_o = flush_q;
    assign misalign_o     = misalign_q;

endmodule
